// File: rtl/ucsbece154b_branch_predictor.sv
// Gshare direction predictor plus direct-mapped BTB: predicts next PC at Fetch,
// carries the prediction to Execute, flags mispredicts and trains there.
module ucsbece154b_branch_predictor #(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_GHR_BITS    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF_i,
    input  logic        StallF_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        FlushE_i,
    output logic        BranchTakenF_o,
    output logic [31:0] BranchTargetF_o,
    input  logic        BranchE_i,
    input  logic        JumpE_i,
    input  logic        PCSrcE_i,
    input  logic [31:0] PCE_i,
    input  logic [31:0] PCTargetE_i,
    input  logic [31:0] PCPlus4E_i,
    output logic        Mispredict_o,
    output logic [31:0] PCRecoverE_o
);

    localparam int unsigned BI    = $clog2(NUM_BTB_ENTRIES);
    localparam int unsigned TAG_W = 32 - BI - 2;
    localparam int unsigned PHT_N = 1 << NUM_GHR_BITS;

    typedef struct packed {
        logic                    taken;
        logic [31:0]             target;
        logic [NUM_GHR_BITS-1:0] pht_idx;
    } pred_rec_t;

    logic [NUM_BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]           btb_tag_q    [NUM_BTB_ENTRIES];
    logic [TAG_W-1:0]           btb_tag_d    [NUM_BTB_ENTRIES];
    logic [31:0]                btb_target_q [NUM_BTB_ENTRIES];
    logic [31:0]                btb_target_d [NUM_BTB_ENTRIES];
    logic [NUM_BTB_ENTRIES-1:0] btb_jump_q, btb_jump_d;
    logic [1:0]                 pht_q [PHT_N];
    logic [1:0]                 pht_d [PHT_N];
    logic [NUM_GHR_BITS-1:0]    ghr_q, ghr_d;
    pred_rec_t                  rec_fd_q, rec_fd_d;
    pred_rec_t                  rec_de_q, rec_de_d;

    logic [BI-1:0]           f_btb_idx;
    logic [TAG_W-1:0]        f_tag;
    logic                    f_hit;
    logic [NUM_GHR_BITS-1:0] f_pht_idx;
    logic [BI-1:0]           e_btb_idx;
    logic                    rv;
    logic                    unused_c;

    // Fetch-side lookup reads only pre-write table contents.
    always_comb begin
        f_btb_idx       = PCF_i[BI+1:2];
        f_tag           = PCF_i[31:BI+2];
        f_hit           = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
        f_pht_idx       = PCF_i[NUM_GHR_BITS+1:2] ^ ghr_q;
        BranchTakenF_o  = ~reset & f_hit & (btb_jump_q[f_btb_idx] | pht_q[f_pht_idx][1]);
        BranchTargetF_o = f_hit ? btb_target_q[f_btb_idx] : 32'h0;
    end

    always_comb begin
        rv           = BranchE_i | JumpE_i;
        e_btb_idx    = PCE_i[BI+1:2];
        Mispredict_o = (rv & (rec_de_q.taken != PCSrcE_i))
                     | (rv & PCSrcE_i & rec_de_q.taken & (rec_de_q.target != PCTargetE_i))
                     | (~rv & rec_de_q.taken);
        PCRecoverE_o = (PCSrcE_i & rv) ? PCTargetE_i : PCPlus4E_i;
    end

    // Next-state: prediction pipeline and non-speculative training at Execute.
    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        btb_jump_d   = btb_jump_q;
        pht_d        = pht_q;
        ghr_d        = ghr_q;
        rec_fd_d     = rec_fd_q;
        rec_de_d     = FlushE_i ? '0 : rec_fd_q;

        if (FlushD_i) begin
            rec_fd_d = '0;
        end else if (!StallD_i) begin
            rec_fd_d.taken   = BranchTakenF_o;
            rec_fd_d.target  = BranchTargetF_o;
            rec_fd_d.pht_idx = f_pht_idx;
        end

        if (rv && PCSrcE_i) begin
            btb_valid_d[e_btb_idx]  = 1'b1;
            btb_tag_d[e_btb_idx]    = PCE_i[31:BI+2];
            btb_target_d[e_btb_idx] = PCTargetE_i;
            btb_jump_d[e_btb_idx]   = JumpE_i;
        end else if (!rv && rec_de_q.taken) begin
            btb_valid_d[e_btb_idx] = 1'b0;
        end

        if (BranchE_i && !JumpE_i) begin
            if (PCSrcE_i && (pht_q[rec_de_q.pht_idx] != 2'b11)) begin
                pht_d[rec_de_q.pht_idx] = pht_q[rec_de_q.pht_idx] + 2'd1;
            end else if (!PCSrcE_i && (pht_q[rec_de_q.pht_idx] != 2'b00)) begin
                pht_d[rec_de_q.pht_idx] = pht_q[rec_de_q.pht_idx] - 2'd1;
            end
            ghr_d = {ghr_q[NUM_GHR_BITS-2:0], PCSrcE_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid_q <= '0;
            ghr_q       <= '0;
            rec_fd_q    <= '0;
            rec_de_q    <= '0;
            for (int unsigned i = 0; i < PHT_N; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            btb_valid_q <= btb_valid_d;
            ghr_q       <= ghr_d;
            rec_fd_q    <= rec_fd_d;
            rec_de_q    <= rec_de_d;
            pht_q       <= pht_d;
        end
    end

    // Payload fields are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        btb_tag_q    <= btb_tag_d;
        btb_target_q <= btb_target_d;
        btb_jump_q   <= btb_jump_d;
    end

    // Fetch holds no state of its own; low PC bits never index anything.
    assign unused_c = ^{StallF_i, PCF_i[1:0], PCE_i[1:0]};

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Randomized bench for the branch predictor, checked every cycle against a
// table-level behavioural model, plus directed scenarios with literal expectations.
module tb_ucsbece154b_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF_i;
    logic        StallF_i, StallD_i, FlushD_i, FlushE_i;
    logic        BranchTakenF_o;
    logic [31:0] BranchTargetF_o;
    logic        BranchE_i, JumpE_i, PCSrcE_i;
    logic [31:0] PCE_i, PCTargetE_i, PCPlus4E_i;
    logic        Mispredict_o;
    logic [31:0] PCRecoverE_o;

    always #5 clk = ~clk;

    ucsbece154b_branch_predictor #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk(clk), .reset(reset), .PCF_i(PCF_i), .StallF_i(StallF_i),
        .StallD_i(StallD_i), .FlushD_i(FlushD_i), .FlushE_i(FlushE_i),
        .BranchTakenF_o(BranchTakenF_o), .BranchTargetF_o(BranchTargetF_o),
        .BranchE_i(BranchE_i), .JumpE_i(JumpE_i), .PCSrcE_i(PCSrcE_i),
        .PCE_i(PCE_i), .PCTargetE_i(PCTargetE_i), .PCPlus4E_i(PCPlus4E_i),
        .Mispredict_o(Mispredict_o), .PCRecoverE_o(PCRecoverE_o)
    );

    int checks = 0;
    int errors = 0;

    // Model state: plain arrays of table contents and the in-flight predictions.
    bit          m_valid [32];
    int unsigned m_tag   [32];
    logic [31:0] m_tgt   [32];
    bit          m_jump  [32];
    int          m_pht   [32];
    int          m_ghr;
    bit          d_tk, e_tk;
    logic [31:0] d_tg, e_tg;
    int          d_ix, e_ix;
    bit          model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_fetch(input logic [31:0] pc, output bit tk,
                                        output logic [31:0] tg, output int ix);
        int bi;
        bit hit;
        bi  = int'((pc >> 2) % 32);
        hit = m_valid[bi] && (m_tag[bi] == int'(pc >> 7));
        ix  = bi ^ m_ghr;
        tk  = hit && (m_jump[bi] || (m_pht[ix] >= 2));
        tg  = hit ? m_tgt[bi] : 32'h0;
    endfunction

    task automatic eval_check();
        bit          tk, rv, mp;
        logic [31:0] tg;
        int          ix;
        #1;
        if (model_ok) begin
            model_fetch(PCF_i, tk, tg, ix);
            rv = BranchE_i || JumpE_i;
            mp = (rv && (e_tk != PCSrcE_i)) ||
                 (rv && PCSrcE_i && e_tk && (e_tg != PCTargetE_i)) ||
                 (!rv && e_tk);
            chk("taken_f", 32'(BranchTakenF_o), 32'(reset ? 1'b0 : tk));
            chk("target_f", BranchTargetF_o, tg);
            chk("mispredict", 32'(Mispredict_o), 32'(mp));
            chk("recover", PCRecoverE_o, (PCSrcE_i && rv) ? PCTargetE_i : PCPlus4E_i);
        end
    endtask

    task automatic advance();
        bit          tk, rv;
        logic [31:0] tg;
        int          ix, bi;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 1'b0;
                m_pht[i]   = 1;
            end
            m_ghr = 0;
            d_tk = 0; d_tg = 0; d_ix = 0;
            e_tk = 0; e_tg = 0; e_ix = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            model_fetch(PCF_i, tk, tg, ix);
            rv = BranchE_i || JumpE_i;
            bi = int'((PCE_i >> 2) % 32);
            if (rv && PCSrcE_i) begin
                m_valid[bi] = 1'b1;
                m_tag[bi]   = int'(PCE_i >> 7);
                m_tgt[bi]   = PCTargetE_i;
                m_jump[bi]  = JumpE_i;
            end else if (!rv && e_tk) begin
                m_valid[bi] = 1'b0;
            end
            if (BranchE_i && !JumpE_i) begin
                m_pht[e_ix] = PCSrcE_i ? ((m_pht[e_ix] < 3) ? m_pht[e_ix] + 1 : 3)
                                       : ((m_pht[e_ix] > 0) ? m_pht[e_ix] - 1 : 0);
                m_ghr = ((m_ghr * 2) + int'(PCSrcE_i)) % 32;
            end
            if (FlushE_i) begin
                e_tk = 0; e_tg = 0; e_ix = 0;
            end else begin
                e_tk = d_tk; e_tg = d_tg; e_ix = d_ix;
            end
            if (FlushD_i) begin
                d_tk = 0; d_tg = 0; d_ix = 0;
            end else if (!StallD_i) begin
                d_tk = tk; d_tg = tg; d_ix = ix;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 0; PCF_i = 32'hF00;
        StallF_i = 0; StallD_i = 0; FlushD_i = 0; FlushE_i = 0;
        BranchE_i = 0; JumpE_i = 0; PCSrcE_i = 0;
        PCE_i = 32'hF00; PCTargetE_i = 32'h0; PCPlus4E_i = 32'hF04;
    endtask

    task automatic set_e(input bit br, input bit jp, input bit tk,
                         input logic [31:0] pc, input logic [31:0] tgt);
        BranchE_i = br; JumpE_i = jp; PCSrcE_i = tk;
        PCE_i = pc; PCTargetE_i = tgt; PCPlus4E_i = pc + 32'd4;
    endtask

    logic [31:0] pc_pool  [6] = '{32'h40, 32'h44, 32'h80, 32'h100, 32'h1040, 32'h1080};
    logic [31:0] tgt_pool [4] = '{32'h20, 32'h200, 32'h300, 32'h44};

    initial begin
        int k;
        set_idle();
        @(negedge clk);
        reset = 1;
        advance();
        advance();
        set_idle();

        // After reset nothing is predicted.
        PCF_i = 32'h100;
        eval_check();
        chk("lit_reset_taken", 32'(BranchTakenF_o), 32'h0);
        chk("lit_reset_target", BranchTargetF_o, 32'h0);
        chk("lit_reset_mispredict", 32'(Mispredict_o), 32'h0);
        advance();

        // First taken beq at 0x40 -> 0x20 with no prediction.
        set_idle();
        set_e(1, 0, 1, 32'h40, 32'h20);
        eval_check();
        chk("lit_beq_mispredict", 32'(Mispredict_o), 32'h1);
        chk("lit_beq_recover", PCRecoverE_o, 32'h20);
        advance();

        // GHR=00001 steers 0x40 to an untrained counter.
        set_idle();
        PCF_i = 32'h40;
        eval_check();
        chk("lit_beq_ghr1_taken", 32'(BranchTakenF_o), 32'h0);
        advance();

        // Fetch, bubble, resolve-taken loops: history saturates, then the counter trains to 3.
        for (int it = 0; it < 10; it++) begin
            set_idle(); PCF_i = 32'h40; eval_check(); advance();
            set_idle(); eval_check(); advance();
            set_idle(); set_e(1, 0, 1, 32'h40, 32'h20); eval_check(); advance();
        end
        set_idle();
        PCF_i = 32'h40;
        eval_check();
        chk("lit_trained_taken", 32'(BranchTakenF_o), 32'h1);
        chk("lit_trained_target", BranchTargetF_o, 32'h20);
        advance();
        set_idle(); eval_check(); advance();
        set_idle();
        set_e(1, 0, 0, 32'h40, 32'h20);
        eval_check();
        chk("lit_nt_mispredict", 32'(Mispredict_o), 32'h1);
        chk("lit_nt_recover", PCRecoverE_o, 32'h44);
        advance();

        // jal at 0x80: first encounter mispredicts, second is predicted.
        set_idle();
        set_e(0, 1, 1, 32'h80, 32'h200);
        eval_check();
        chk("lit_jal1_mispredict", 32'(Mispredict_o), 32'h1);
        chk("lit_jal1_recover", PCRecoverE_o, 32'h200);
        advance();
        set_idle();
        PCF_i = 32'h80;
        eval_check();
        chk("lit_jal2_taken", 32'(BranchTakenF_o), 32'h1);
        chk("lit_jal2_target", BranchTargetF_o, 32'h200);
        advance();
        set_idle(); eval_check(); advance();
        set_idle();
        set_e(0, 1, 1, 32'h80, 32'h200);
        eval_check();
        chk("lit_jal2_mispredict", 32'(Mispredict_o), 32'h0);
        advance();

        // Hold a taken record in D for two cycles, then flush E.
        set_idle(); PCF_i = 32'h80; eval_check(); advance();
        set_idle(); StallD_i = 1; eval_check(); advance();
        set_idle(); StallD_i = 1; eval_check(); advance();
        set_idle(); FlushE_i = 1; eval_check(); advance();
        set_idle();
        eval_check();
        chk("lit_bubble_mispredict", 32'(Mispredict_o), 32'h0);
        advance();

        // Reset in the middle of a training cycle.
        set_idle();
        PCF_i = 32'h40;
        set_e(1, 0, 1, 32'h40, 32'h20);
        reset = 1;
        eval_check();
        chk("lit_reset_mid_taken", 32'(BranchTakenF_o), 32'h0);
        advance();
        set_idle();
        PCF_i = 32'h80;
        eval_check();
        chk("lit_after_reset_taken", 32'(BranchTakenF_o), 32'h0);
        chk("lit_after_reset_target", BranchTargetF_o, 32'h0);
        chk("lit_after_reset_mispredict", 32'(Mispredict_o), 32'h0);
        advance();

        // Randomized traffic over a small PC pool so hits, aliasing and retraining occur.
        for (int n = 0; n < 4000; n++) begin
            set_idle();
            reset    = ($urandom_range(255) == 0);
            PCF_i    = pc_pool[$urandom_range(5)];
            StallF_i = ($urandom_range(4) == 0);
            StallD_i = ($urandom_range(4) == 0);
            FlushD_i = ($urandom_range(7) == 0);
            FlushE_i = ($urandom_range(7) == 0);
            k = int'($urandom_range(3));
            set_e(k == 1 || k == 3, k == 2, (k == 2) ? 1'b1 : 1'($urandom_range(1)),
                  pc_pool[$urandom_range(5)], tgt_pool[$urandom_range(3)]);
            eval_check();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
